// File: rtl/spi_accel_burst_reader_if.sv
// SPI pin bundle between the accelerometer burst reader (master) and the device (slave).
interface spi_accel_burst_reader_if;
  logic CS;
  logic SDO;
  logic SCLK_out;
  logic SDI;

  modport master (output CS, output SDO, output SCLK_out, input SDI);
  modport slave  (input CS, input SDO, input SCLK_out, output SDI);
endinterface

// File: rtl/spi_accel_burst_reader.sv
// SPI mode-0 master that burst-reads NUM_AXES accelerometer registers (0x0B read + START_ADDR)
// and publishes the whole frame atomically, once or continuously with a CS-high gap.
module spi_accel_burst_reader #(
  parameter int          CLK_DIV    = 4,
  parameter int          NUM_AXES   = 3,
  parameter int          DATA_W     = 8,
  parameter logic [7:0]  START_ADDR = 8'h08,
  parameter int          GAP_CYC    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         continuous,
  spi_accel_burst_reader_if.master     spi,
  output logic                         busy,
  output logic                         data_valid,
  output logic [NUM_AXES*DATA_W-1:0]   axis_data,
  output logic [7:0]                   frame_count
);

  localparam int SHADOW_W = NUM_AXES * DATA_W;
  localparam int NBYTES   = SHADOW_W / 8;
  localparam int NBITS    = 16 + SHADOW_W;
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int BIT_W    = $clog2(NBITS);
  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] BIT_HDR  = BIT_W'(16);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [15:0]      HDR      = {8'h0B, START_ADDR};

  if (CLK_DIV < 2) begin : g_bad_div
    $error("CLK_DIV must be >= 2");
  end
  if (NUM_AXES < 1 || NUM_AXES > 4) begin : g_bad_axes
    $error("NUM_AXES must be 1..4");
  end
  if (DATA_W != 8 && DATA_W != 16) begin : g_bad_w
    $error("DATA_W must be 8 or 16");
  end
  if (GAP_CYC < 1) begin : g_bad_gap
    $error("GAP_CYC must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_e;

  state_e                   state_q, state_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [BIT_W-1:0]         bit_q, bit_d;
  logic                     phase_q, phase_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [15:0]              tx_q, tx_d;
  logic [7:0]               rx_byte_q, rx_byte_d;
  logic [NBYTES-1:0][7:0]   shadow_q, shadow_d;
  logic [SHADOW_W-1:0]      axis_q, axis_d;
  logic                     dv_q, dv_d;
  logic [7:0]               fc_q, fc_d;
  logic                     div_done;
  logic                     cs_low;

  assign div_done = (div_q == DIV_LAST);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    phase_d   = phase_q;
    gap_d     = gap_q;
    tx_d      = tx_q;
    rx_byte_d = rx_byte_q;
    shadow_d  = shadow_q;
    axis_d    = axis_q;
    dv_d      = 1'b0;
    fc_d      = fc_q;

    case (state_q)
      S_IDLE: begin
        if (start || continuous) begin
          state_d = S_SETUP;
          div_d   = '0;
          tx_d    = HDR;
        end
      end

      S_SETUP: begin
        if (div_done) begin
          state_d = S_SHIFT;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (!div_done) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d   = '0;
          phase_d = ~phase_q;
          if (!phase_q) begin
            // SCLK rising: sample; a full byte lands in its shadow slot (byte j -> bits 8j+7:8j)
            if (bit_q >= BIT_HDR) begin
              rx_byte_d = {rx_byte_q[6:0], spi.SDI};
              for (int j = 0; j < NBYTES; j++) begin
                if (int'(bit_q) == 23 + 8 * j) shadow_d[j] = rx_byte_d;
              end
            end
          end else begin
            // SCLK falling: advance MOSI so it only changes while SCLK is low
            tx_d = {tx_q[14:0], 1'b0};
            if (bit_q == BIT_LAST) begin
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end

      S_HOLD: begin
        if (div_done) begin
          div_d   = '0;
          gap_d   = '0;
          axis_d  = shadow_q;
          dv_d    = 1'b1;
          fc_d    = fc_q + 8'd1;
          state_d = continuous ? S_GAP : S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_SETUP;
          div_d   = '0;
          tx_d    = HDR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      phase_q   <= 1'b0;
      gap_q     <= '0;
      tx_q      <= '0;
      rx_byte_q <= '0;
      shadow_q  <= '0;
      axis_q    <= '0;
      dv_q      <= 1'b0;
      fc_q      <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      phase_q   <= phase_d;
      gap_q     <= gap_d;
      tx_q      <= tx_d;
      rx_byte_q <= rx_byte_d;
      shadow_q  <= shadow_d;
      axis_q    <= axis_d;
      dv_q      <= dv_d;
      fc_q      <= fc_d;
    end
  end

  assign cs_low       = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign spi.CS       = ~cs_low;
  assign spi.SCLK_out = (state_q == S_SHIFT) && phase_q;
  assign spi.SDO      = cs_low & tx_q[15];
  assign busy         = (state_q != S_IDLE);
  assign data_valid   = dv_q;
  assign axis_data    = axis_q;
  assign frame_count  = fc_q;

endmodule

// File: tb/tb_spi_accel_burst_reader.sv
// Scoreboarded bench: three reader configurations, each with a behavioural SPI slave.
module tb_spi_accel_burst_reader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sbit(input logic [63:0] d, input int i);
    int k;
    if (i < 16) return 1'b0;
    k = i - 16;
    if (k >= 64) return 1'b0;
    return d[8 * (k / 8) + 7 - (k % 8)];
  endfunction

  // ---------------- DUT 0: defaults ----------------
  spi_accel_burst_reader_if if0();
  logic start0, cont0, busy0, dv0;
  logic [23:0] axis0;
  logic [7:0]  fc0;
  spi_accel_burst_reader u0 (
    .clk(clk), .reset(rst), .start(start0), .continuous(cont0), .spi(if0),
    .busy(busy0), .data_valid(dv0), .axis_data(axis0), .frame_count(fc0)
  );

  // ---------------- DUT 1: 2 x 16-bit axes ----------------
  spi_accel_burst_reader_if if1();
  logic start1, cont1, busy1, dv1;
  logic [31:0] axis1;
  logic [7:0]  fc1;
  spi_accel_burst_reader #(.CLK_DIV(2), .NUM_AXES(2), .DATA_W(16), .START_ADDR(8'h0E), .GAP_CYC(4)) u1 (
    .clk(clk), .reset(rst), .start(start1), .continuous(cont1), .spi(if1),
    .busy(busy1), .data_valid(dv1), .axis_data(axis1), .frame_count(fc1)
  );

  // ---------------- DUT 2: short frames for the wrap test ----------------
  spi_accel_burst_reader_if if2();
  logic start2, cont2, busy2, dv2;
  logic [7:0] axis2;
  logic [7:0] fc2;
  spi_accel_burst_reader #(.CLK_DIV(2), .NUM_AXES(1), .DATA_W(8), .START_ADDR(8'h08), .GAP_CYC(1)) u2 (
    .clk(clk), .reset(rst), .start(start2), .continuous(cont2), .spi(if2),
    .busy(busy2), .data_valid(dv2), .axis_data(axis2), .frame_count(fc2)
  );

  // ---------------- slave models ----------------
  logic [63:0] s0_data = '0, s1_data = '0, s2_data = '0;
  logic [15:0] s0_cmd = '0;
  int s0_edges = 0, s0_frame_edges = 0, s1_edges = 0, s2_edges = 0;
  logic s0_sp = 1'b0, s1_sp = 1'b0, s2_sp = 1'b0;

  always @(if0.CS or if0.SCLK_out) begin
    if (if0.CS === 1'b1) begin
      if (s0_edges != 0) s0_frame_edges = s0_edges;
      s0_edges = 0;
    end else if (if0.SCLK_out === 1'b1 && !s0_sp) begin
      if (s0_edges < 16) s0_cmd = {s0_cmd[14:0], if0.SDO};
      s0_edges++;
    end
    if (if0.SCLK_out !== 1'b1) if0.SDI = sbit(s0_data, s0_edges);
    s0_sp = (if0.SCLK_out === 1'b1);
  end

  always @(if1.CS or if1.SCLK_out) begin
    if (if1.CS === 1'b1) s1_edges = 0;
    else if (if1.SCLK_out === 1'b1 && !s1_sp) s1_edges++;
    if (if1.SCLK_out !== 1'b1) if1.SDI = sbit(s1_data, s1_edges);
    s1_sp = (if1.SCLK_out === 1'b1);
  end

  always @(if2.CS or if2.SCLK_out) begin
    if (if2.CS === 1'b1) s2_edges = 0;
    else if (if2.SCLK_out === 1'b1 && !s2_sp) s2_edges++;
    if (if2.SCLK_out !== 1'b1) if2.SDI = sbit(s2_data, s2_edges);
    s2_sp = (if2.SCLK_out === 1'b1);
  end

  // ---------------- CS timing and SDO stability observers ----------------
  int lo_cnt = 0, hi_cnt = 0, last_lo = 0, last_hi = 0;
  int viol0 = 0, viol2 = 0;
  logic sdo0_p = 1'b0, sclk0_p = 1'b0, sdo2_p = 1'b0, sclk2_p = 1'b0;

  always @(negedge clk) begin
    if (if0.CS === 1'b0) begin
      if (hi_cnt != 0) last_hi = hi_cnt;
      hi_cnt = 0;
      lo_cnt++;
    end else begin
      if (lo_cnt != 0) last_lo = lo_cnt;
      lo_cnt = 0;
      hi_cnt = (busy0 === 1'b1) ? hi_cnt + 1 : 0;
    end
    if (if0.SCLK_out === 1'b1 && sclk0_p && if0.SDO !== sdo0_p) viol0++;
    if (if2.SCLK_out === 1'b1 && sclk2_p && if2.SDO !== sdo2_p) viol2++;
    sdo0_p = if0.SDO;  sclk0_p = (if0.SCLK_out === 1'b1);
    sdo2_p = if2.SDO;  sclk2_p = (if2.SCLK_out === 1'b1);
  end

  // ---------------- scoreboards ----------------
  logic [31:0] q0[$];   // {axis, frame_count}
  logic [39:0] q1[$];
  logic [15:0] q2[$];
  int dv_cnt0 = 0, dv_cnt1 = 0, dv_cnt2 = 0;

  always @(negedge clk) begin
    if (rst === 1'b0 && dv0 === 1'b1) begin
      logic [31:0] e;
      dv_cnt0++;
      if (q0.size() == 0) chk("u0_unexpected_valid", {axis0, fc0}, 32'h0);
      else begin
        e = q0.pop_front();
        chk("u0_axis_data", axis0, e[31:8]);
        chk("u0_frame_count", fc0, e[7:0]);
      end
    end
    if (rst === 1'b0 && dv1 === 1'b1) begin
      logic [39:0] e;
      dv_cnt1++;
      if (q1.size() == 0) chk("u1_unexpected_valid", {axis1, fc1}, 40'h0);
      else begin
        e = q1.pop_front();
        chk("u1_axis_data", axis1, e[39:8]);
        chk("u1_frame_count", fc1, e[7:0]);
      end
    end
    if (rst === 1'b0 && dv2 === 1'b1) begin
      logic [15:0] e;
      dv_cnt2++;
      if (q2.size() == 0) chk("u2_unexpected_valid", {axis2, fc2}, 16'h0);
      else begin
        e = q2.pop_front();
        chk("u2_axis_data", axis2, e[15:8]);
        chk("u2_frame_count", fc2, e[7:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  int base;

  initial begin
    rst = 1'b1;
    start0 = 0; cont0 = 0; start1 = 0; cont1 = 0; start2 = 0; cont2 = 0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_cs", if0.CS, 1);
    chk("rst_sclk", if0.SCLK_out, 0);
    chk("rst_sdo", if0.SDO, 0);
    chk("rst_busy_dv", {busy0, dv0}, 0);
    chk("rst_axis_fc", {axis0, fc0}, 0);

    // reset mid-frame aborts on the next edge
    start0 = 1; @(negedge clk) start0 = 0;
    repeat (100) @(negedge clk);
    chk("midframe_cs_low", if0.CS, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_cs", if0.CS, 1);
    chk("abort_sclk", if0.SCLK_out, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_axis_fc", {axis0, fc0}, 0);
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // single read with defaults
    s0_data = 64'h3CA563;
    q0.push_back({24'h3CA563, 8'd1});
    base = dv_cnt0;
    start0 = 1; @(negedge clk) start0 = 0;
    for (int i = 0; i < 2000 && busy0; i++) @(negedge clk);
    chk("single_timeout", busy0, 0);
    repeat (2) @(negedge clk);
    chk("single_cs_low_cycles", last_lo, 328);
    chk("single_sclk_edges", s0_frame_edges, 40);
    chk("single_tx_bytes", s0_cmd, 16'h0B08);
    chk("single_dv_pulses", dv_cnt0 - base, 1);

    // start pulse while busy is ignored
    s0_data = 64'hC0FFEE;
    q0.push_back({24'hC0FFEE, 8'd2});
    base = dv_cnt0;
    start0 = 1; @(negedge clk) start0 = 0;
    repeat (150) @(negedge clk);
    start0 = 1; @(negedge clk) start0 = 0;
    for (int i = 0; i < 2000 && busy0; i++) @(negedge clk);
    chk("busy_start_timeout", busy0, 0);
    repeat (20) @(negedge clk);
    chk("busy_start_fc", fc0, 2);
    chk("busy_start_dv_pulses", dv_cnt0 - base, 1);
    chk("busy_start_no_relaunch", busy0, 0);

    // continuous: three frames, then drop continuous inside frame 4
    s0_data = 64'hA00102;
    for (int i = 3; i <= 6; i++) q0.push_back({24'hA00102, 8'(i)});
    base = dv_cnt0;
    cont0 = 1;
    for (int i = 0; i < 3000 && (dv_cnt0 - base) < 3; i++) @(negedge clk);
    chk("cont_three_frames", dv_cnt0 - base, 3);
    chk("cont_fc_after3", fc0, 5);
    chk("cont_gap_cycles", last_hi, 64);
    for (int i = 0; i < 200 && if0.CS !== 1'b0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    cont0 = 0;
    for (int i = 0; i < 2000 && busy0; i++) @(negedge clk);
    chk("cont_stop_timeout", busy0, 0);
    repeat (500) @(negedge clk);
    chk("cont_stop_dv_pulses", dv_cnt0 - base, 4);
    chk("cont_stop_fc", fc0, 6);
    chk("cont_stop_idle", busy0, 0);
    chk("u0_sdo_stable", viol0, 0);

    // 16-bit axes, little-endian byte order
    s1_data = 64'h56781234;
    q1.push_back({32'h56781234, 8'd1});
    start1 = 1; @(negedge clk) start1 = 0;
    for (int i = 0; i < 2000 && busy1; i++) @(negedge clk);
    chk("w16_timeout", busy1, 0);
    chk("w16_fc", fc1, 1);

    // frame_count wrap over 256 continuous frames
    s2_data = 64'h5A;
    for (int i = 1; i <= 256; i++) q2.push_back({8'h5A, 8'(i)});
    cont2 = 1;
    for (int i = 0; i < 40000 && dv_cnt2 < 255; i++) @(negedge clk);
    chk("wrap_255_frames", dv_cnt2, 255);
    cont2 = 0;
    for (int i = 0; i < 1000 && busy2; i++) @(negedge clk);
    chk("wrap_timeout", busy2, 0);
    repeat (5) @(negedge clk);
    chk("wrap_dv_total", dv_cnt2, 256);
    chk("wrap_fc_zero", fc2, 0);
    chk("u2_sdo_stable", viol2, 0);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
